// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch front end: instruction width,
// the canonical NOP and the ROM read latency the inflight tracking assumes.
package if_prefetch_pkg;

    localparam int INST_W = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

    // Read data follows the request by exactly one cycle; a single inflight
    // flag is enough to track the outstanding read.
    localparam int ROM_LATENCY = 1;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// DEPTH-entry register queue of {instruction, address} pairs with push, pop,
// synchronous clear and registered head outputs (NOP / zero address when empty).
module if_prefetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              head_valid_o,
    output logic [INST_W-1:0] head_inst_o,
    output logic [ADDR_W-1:0] head_addr_o
);

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign do_push = push_i;
    assign do_pop  = pop_i && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i && do_push) begin
            inst_mem_q[wr_ptr_q] <= push_inst_i;
            addr_mem_q[wr_ptr_q] <= push_addr_i;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = !empty;
    assign head_inst_o  = empty ? INST_NOP : inst_mem_q[rd_ptr_q];
    assign head_addr_o  = empty ? '0 : addr_mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential ROM reads
// under a credit rule, queues returned words and redirects on ctrl jumps.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_ready_i
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    // Low during reset, high from the first edge with rst released; keeps
    // rom_req_o quiet while held in reset without an extra rst-to-output path.
    logic              running_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              head_valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    credit_used;
    logic [ADDR_W-1:0] jump_target;

    assign pop  = head_valid && inst_ready_i;
    assign push = inflight_q && !jump_en_i;

    // Entries that will be occupied after this cycle's pop, including the
    // word still on its way back from the ROM.
    assign credit_used = (CNT_W + 1)'(fifo_count)
                       + (CNT_W + 1)'(inflight_q)
                       - (CNT_W + 1)'(pop);

    assign issue       = running_q && !jump_en_i && (credit_used < DEPTH_C);
    assign jump_target = jump_addr_i & ~ADDR_W'(3);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (jump_en_i) begin
            fetch_pc_d = jump_target;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
            inflight_pc_d = fetch_pc_q;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            running_q     <= 1'b1;
        end
    end

    if_prefetch_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst),
        .clear_i      (jump_en_i),
        .push_i       (push),
        .push_inst_i  (rom_data_i),
        .push_addr_i  (inflight_pc_q),
        .pop_i        (pop),
        .count_o      (fifo_count),
        .head_valid_o (head_valid),
        .head_inst_o  (inst_o),
        .head_addr_o  (inst_addr_o)
    );

    assign rom_req_o    = issue;
    assign rom_addr_o   = fetch_pc_q;
    assign inst_valid_o = head_valid;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: reset, streaming, stall/resume, jumps,
// mid-stream reset and PC wrap-around on a second instance.
module tb_if_prefetch;

    localparam int          ADDR_W  = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        ready;

    logic        req0, req1;
    logic [31:0] raddr0, raddr1;
    logic [31:0] rdata0, rdata1;
    logic        valid0, valid1;
    logic [31:0] inst0, inst1;
    logic [31:0] iaddr0, iaddr1;

    int n_vec = 0;
    int n_err = 0;
    int n_req;

    if_prefetch #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .rom_req_o    (req0),
        .rom_addr_o   (raddr0),
        .rom_data_i   (rdata0),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .inst_valid_o (valid0),
        .inst_o       (inst0),
        .inst_addr_o  (iaddr0),
        .inst_ready_i (ready)
    );

    if_prefetch #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (WRAP_PC)
    ) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .rom_req_o    (req1),
        .rom_addr_o   (raddr1),
        .rom_data_i   (rdata1),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .inst_valid_o (valid1),
        .inst_o       (inst1),
        .inst_addr_o  (iaddr1),
        .inst_ready_i (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Synchronous ROM: address-encoded data one cycle after the request.
    always @(posedge clk) begin
        rdata0 <= rom_word(raddr0);
        rdata1 <= rom_word(raddr1);
    end

    always @(negedge clk) begin
        if (rst) begin
            assert (u_dut.fifo_count <= 3'(DEPTH)) else begin
                n_err++;
                $error("FAIL count_bound: observed %0d expected <= %0d", u_dut.fifo_count, DEPTH);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        ready     = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
        repeat (3) step();

        chk("rst_req",        32'(req0),   32'd0);
        chk("rst_valid",      32'(valid0), 32'd0);
        chk("rst_inst",       inst0,       NOP);
        chk("rst_iaddr",      iaddr0,      32'h0);
        chk("rst_raddr",      raddr0,      32'h0);
        chk("rst_wrap_raddr", raddr1,      WRAP_PC);

        // Release reset with decode ready: first head two cycles after E0.
        ready = 1'b1;
        rst   = 1'b1;
        #1;
        chk("pre_e0_req", 32'(req0), 32'd0);
        step();
        chk("e0_req",   32'(req0),   32'd1);
        chk("e0_raddr", raddr0,      32'h0);
        chk("e0_valid", 32'(valid0), 32'd0);
        step();
        chk("e1_valid", 32'(valid0), 32'd0);
        chk("e1_raddr", raddr0,      32'h4);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stream_valid", 32'(valid0), 32'd1);
            chk("stream_iaddr", iaddr0,      32'(i * 4));
            chk("stream_inst",  inst0,       rom_word(32'(i * 4)));
        end

        // Restart with decode stalled: exactly DEPTH requests, then none.
        rst   = 1'b0;
        ready = 1'b0;
        step();
        rst   = 1'b1;
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_req += int'(req0);
        end
        chk("stall_req_count", 32'(n_req),  32'd4);
        chk("stall_req_off",   32'(req0),   32'd0);
        chk("stall_valid",     32'(valid0), 32'd1);
        chk("stall_head",      iaddr0,      32'h0);

        ready = 1'b1;
        #1;
        chk("resume_req",   32'(req0), 32'd1);
        chk("resume_raddr", raddr0,    32'h10);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_valid", 32'(valid0), 32'd1);
            chk("drain_iaddr", iaddr0,      32'(i * 4));
        end

        // Jump to an unaligned target with a nearly full queue and a read in flight.
        ready     = 1'b0;
        jump_en   = 1'b1;
        jump_addr = 32'h103;
        #1;
        chk("jump_req_blocked", 32'(req0), 32'd0);
        step();
        jump_en = 1'b0;
        ready   = 1'b1;
        #1;
        chk("j1_valid", 32'(valid0), 32'd0);
        chk("j1_inst",  inst0,       NOP);
        chk("j1_iaddr", iaddr0,      32'h0);
        chk("j1_req",   32'(req0),   32'd1);
        chk("j1_raddr", raddr0,      32'h100);
        step();
        chk("j2_valid", 32'(valid0), 32'd0);
        chk("j2_raddr", raddr0,      32'h104);
        step();
        chk("j3_valid", 32'(valid0), 32'd1);
        chk("j3_iaddr", iaddr0,      32'h100);
        chk("j3_inst",  inst0,       rom_word(32'h100));
        step();
        chk("j4_iaddr", iaddr0,      32'h104);
        step();
        chk("j5_iaddr", iaddr0,      32'h108);

        // Jump coinciding with a transfer and an arriving response.
        jump_en   = 1'b1;
        jump_addr = 32'h200;
        #1;
        chk("x0_xfer_valid", 32'(valid0), 32'd1);
        step();
        jump_en = 1'b0;
        #1;
        chk("x1_valid", 32'(valid0), 32'd0);
        chk("x1_raddr", raddr0,      32'h200);
        step();
        chk("x2_valid", 32'(valid0), 32'd0);
        step();
        chk("x3_valid", 32'(valid0), 32'd1);
        chk("x3_iaddr", iaddr0,      32'h200);
        step();
        chk("x4_iaddr", iaddr0,      32'h204);

        // One-cycle reset mid-stream; the second instance checks PC wrap.
        rst = 1'b0;
        step();
        chk("mr_req",        32'(req0),   32'd0);
        chk("mr_valid",      32'(valid0), 32'd0);
        chk("mr_inst",       inst0,       NOP);
        chk("mr_iaddr",      iaddr0,      32'h0);
        chk("mr_raddr",      raddr0,      32'h0);
        chk("mr_wrap_valid", 32'(valid1), 32'd0);
        chk("mr_wrap_raddr", raddr1,      WRAP_PC);
        rst = 1'b1;
        step();
        chk("mr_e0_req",   32'(req0), 32'd1);
        chk("mr_e0_raddr", raddr0,    32'h0);
        step();
        step();
        chk("mr_head0",   iaddr0, 32'h0);
        chk("wrap_head0", iaddr1, 32'hFFFF_FFF8);
        chk("wrap_inst0", inst1,  rom_word(32'hFFFF_FFF8));
        step();
        chk("mr_head1",   iaddr0, 32'h4);
        chk("wrap_head1", iaddr1, 32'hFFFF_FFFC);
        step();
        chk("mr_head2",   iaddr0, 32'h8);
        chk("wrap_head2", iaddr1, 32'h0000_0000);
        chk("wrap_valid", 32'(valid1), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
